seg7_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 39 +++
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg7_scan_driver.sv | 152 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the scanned 7-segment driver: FSM encoding,
// hex segment patterns (active-high, seg[0]=a .. seg[6]=g) and a polarity helper.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_SHOW,
    ST_GUARD
  } state_e;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  localparam logic [6:0] HEX_SEG [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
  };

  // Converts an active-high pattern to the board's pin polarity.
  function automatic logic [7:0] applyPolarity(input logic [7:0] activeHigh,
                                               input logic       activeLow);
    return activeLow ? ~activeHigh : activeHigh;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-high 7-segment pattern lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with dwell/guard scan timing,
// frame-aligned double buffering and leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 50000,
  parameter int GUARD          = 500,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ACTIVE_LOW_AN  = 1,
  localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    pending
);

  localparam int CNT_MAX = (PRESCALE > GUARD) ? PRESCALE : GUARD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [6:0]            SEG_OFF = 7'(applyPolarity(8'h00, ACTIVE_LOW_SEG != 0));
  localparam logic                  DP_OFF  = (ACTIVE_LOW_SEG != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = NUM_DIGITS'(applyPolarity(8'h00, ACTIVE_LOW_AN != 0));

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [4*NUM_DIGITS-1:0] dispVal_q, shadowVal_q;
  logic [NUM_DIGITS-1:0]   dispDp_q, shadowDp_q;
  logic                    dispBlz_q, shadowBlz_q;
  logic                    pending_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_q;
  logic                    dp_q;

  logic [IDX_W-1:0]        idxInc, showIdx;
  logic [4*NUM_DIGITS-1:0] srcVal;
  logic [NUM_DIGITS-1:0]   srcDp;
  logic                    srcBlz, blankDigit;
  logic [3:0]              nibble;
  logic [6:0]              hexSeg, segShow;
  logic                    dpShow;
  logic [NUM_DIGITS-1:0]   anShow;
  logic                    showDone, guardDone, enterShow, enterGuard;

  // Select the digit about to be lit and the value it will come from; at
  // digit-0 entry a same-edge load beats the shadow, which beats the display.
  always_comb begin
    idxInc = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    case (state_q)
      ST_OFF:   showIdx = '0;
      ST_GUARD: showIdx = idx_q;
      default:  showIdx = idxInc;
    endcase
    srcVal = dispVal_q;
    srcDp  = dispDp_q;
    srcBlz = dispBlz_q;
    if (showIdx == '0) begin
      if (load) begin
        srcVal = value;
        srcDp  = dp_in;
        srcBlz = blank_lz;
      end else if (pending_q) begin
        srcVal = shadowVal_q;
        srcDp  = shadowDp_q;
        srcBlz = shadowBlz_q;
      end
    end
    nibble     = srcVal[4*showIdx +: 4];
    blankDigit = srcBlz && (showIdx != '0) && ((srcVal >> (4*showIdx)) == '0);
  end

  seg7_hex_decode uHexDecode (
    .nibble_i(nibble),
    .seg_o   (hexSeg)
  );

  assign segShow = blankDigit ? 7'h00 : hexSeg;
  assign dpShow  = !blankDigit && srcDp[showIdx];
  assign anShow  = NUM_DIGITS'(1) << showIdx;

  assign showDone   = (cnt_q == CNT_W'(PRESCALE - 1));
  assign guardDone  = (cnt_q == CNT_W'(GUARD - 1));
  assign enterShow  = ((state_q == ST_OFF) && load)
                   || ((state_q == ST_SHOW) && showDone && (GUARD == 0))
                   || ((state_q == ST_GUARD) && guardDone);
  assign enterGuard = (state_q == ST_SHOW) && showDone && (GUARD != 0);

  // During GUARD idx_q already holds the next digit to be lit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      idx_q       <= '0;
      dispVal_q   <= '0;
      dispDp_q    <= '0;
      dispBlz_q   <= 1'b0;
      shadowVal_q <= '0;
      shadowDp_q  <= '0;
      shadowBlz_q <= 1'b0;
      pending_q   <= 1'b0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_OFF;
      dp_q        <= DP_OFF;
    end else begin
      if (enterShow) begin
        state_q <= ST_SHOW;
        cnt_q   <= '0;
        idx_q   <= showIdx;
        an_q    <= NUM_DIGITS'(applyPolarity(8'(anShow), ACTIVE_LOW_AN != 0));
        seg_q   <= 7'(applyPolarity({1'b0, segShow}, ACTIVE_LOW_SEG != 0));
        dp_q    <= dpShow ^ DP_OFF;
      end else if (enterGuard) begin
        state_q <= ST_GUARD;
        cnt_q   <= '0;
        idx_q   <= idxInc;
        an_q    <= AN_OFF;
        seg_q   <= SEG_OFF;
        dp_q    <= DP_OFF;
      end else if (state_q != ST_OFF) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (enterShow && (showIdx == '0)) begin
        dispVal_q <= srcVal;
        dispDp_q  <= srcDp;
        dispBlz_q <= srcBlz;
        pending_q <= 1'b0;
      end else if (load && (state_q != ST_OFF)) begin
        shadowVal_q <= value;
        shadowDp_q  <= dp_in;
        shadowBlz_q <= blank_lz;
        pending_q   <= 1'b1;
      end
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_idx = idx_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (4 digits, dwell 4, guard 1, active-low pins):
// frame-position scoreboard, decode vector table and scan corner sequences.
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int PS    = 4;
  localparam int GD    = 1;
  localparam int FRAME = N * (PS + GD);
  localparam int NVEC  = 7;

  localparam logic [6:0] TB_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk     = 1'b0;
  logic        resetn  = 1'b0;
  logic        load    = 1'b0;
  logic [15:0] value   = 16'h0;
  logic [3:0]  dpIn    = 4'h0;
  logic        blankLz = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digitIdx;
  logic        pending;

  int assertCount = 0;
  int failCount   = 0;

  seg7_scan_driver #(
    .NUM_DIGITS    (N),
    .PRESCALE      (PS),
    .GUARD         (GD),
    .ACTIVE_LOW_SEG(1),
    .ACTIVE_LOW_AN (1)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .load     (load),
    .value    (value),
    .dp_in    (dpIn),
    .blank_lz (blankLz),
    .seg      (seg),
    .dp       (dp),
    .an       (an),
    .digit_idx(digitIdx),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       pend;
    logic       idxValid;
    logic [1:0] idx;
  } expect_t;

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dpIn;
    logic            blz;
    logic [3:0][6:0] expSeg;
    logic [3:0]      expDp;
  } vec_t;

  expect_t sbQ[$];
  vec_t    vecs[NVEC];

  // Reference model: tracks position inside the 20-cycle frame
  bit          mOn    = 1'b0;
  int          mPos   = 0;
  logic [15:0] mVal   = '0, mShVal = '0;
  logic [3:0]  mDp    = '0, mShDp  = '0;
  logic        mBlz   = 1'b0, mShBlz = 1'b0, mPend = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelStep();
    expect_t     e;
    int          d;
    logic [3:0]  nib;
    logic        blank;
    if (!resetn) begin
      mOn = 1'b0; mPos = 0; mPend = 1'b0;
      mVal = '0; mDp = '0; mBlz = 1'b0;
      mShVal = '0; mShDp = '0; mShBlz = 1'b0;
    end else if (!mOn) begin
      if (load) begin
        mOn = 1'b1; mPos = 0;
        mVal = value; mDp = dpIn; mBlz = blankLz;
      end
    end else begin
      mPos = (mPos + 1) % FRAME;
      if (mPos == 0 && load) begin
        mVal = value; mDp = dpIn; mBlz = blankLz; mPend = 1'b0;
      end else if (mPos == 0 && mPend) begin
        mVal = mShVal; mDp = mShDp; mBlz = mShBlz; mPend = 1'b0;
      end else if (load) begin
        mShVal = value; mShDp = dpIn; mShBlz = blankLz; mPend = 1'b1;
      end
    end
    e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.pend = mPend;
    e.idxValid = !mOn; e.idx = 2'd0;
    if (mOn && (mPos % (PS + GD)) < PS) begin
      d     = mPos / (PS + GD);
      nib   = mVal[4*d +: 4];
      blank = mBlz && (d != 0) && ((mVal >> (4*d)) == 16'h0);
      e.an  = ~(4'b0001 << d);
      e.seg = blank ? 7'h7F : ~TB_SEG[nib];
      e.dp  = blank ? 1'b1 : ~mDp[d];
      e.idxValid = 1'b1;
      e.idx = 2'(d);
    end
    sbQ.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  initial forever begin
    expect_t e;
    @(negedge clk);
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput("sb_an", 32'(an), 32'(e.an));
      checkOutput("sb_seg", 32'(seg), 32'(e.seg));
      checkOutput("sb_dp", 32'(dp), 32'(e.dp));
      checkOutput("sb_pending", 32'(pending), 32'(e.pend));
      if (e.idxValid) checkOutput("sb_digit_idx", 32'(digitIdx), 32'(e.idx));
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; load is sampled on the following posedge.
  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d, input logic b);
    value   = v;
    dpIn    = d;
    blankLz = b;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  task automatic checkBlank(input string name);
    checkOutput({name, "_an"}, 32'(an), 32'(4'hF));
    checkOutput({name, "_seg"}, 32'(seg), 32'(7'h7F));
    checkOutput({name, "_dp"}, 32'(dp), 32'(1'b1));
    checkOutput({name, "_pending"}, 32'(pending), 32'(1'b0));
  endtask

  initial begin
    logic [6:0] expSegV;
    logic       expDpV;
    logic [3:0] expAnV;

    vecs[0] = '{16'h12AF, 4'b0000, 1'b0, {7'h06, 7'h5B, 7'h77, 7'h71}, 4'b0000};
    vecs[1] = '{16'h0050, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h6D, 7'h3F}, 4'b0000};
    vecs[2] = '{16'h0000, 4'b1111, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0001};
    vecs[3] = '{16'h89BC, 4'b1010, 1'b0, {7'h7F, 7'h6F, 7'h7C, 7'h39}, 4'b1010};
    vecs[4] = '{16'h00E0, 4'b1111, 1'b1, {7'h00, 7'h00, 7'h79, 7'h3F}, 4'b0011};
    vecs[5] = '{16'h3456, 4'b0000, 1'b1, {7'h4F, 7'h66, 7'h6D, 7'h7D}, 4'b0000};
    vecs[6] = '{16'h0D07, 4'b1100, 1'b1, {7'h00, 7'h5E, 7'h3F, 7'h07}, 4'b0100};

    // Reset for three edges, then idle with no load
    waitCycles(3);
    resetn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      waitCycles(1);
      checkBlank("idle");
      checkOutput("idle_digit_idx", 32'(digitIdx), 32'(2'd0));
    end

    // First load from OFF is visible one cycle later
    applyStimulus(16'h12AF, 4'h0, 1'b0);
    checkOutput("first_an", 32'(an), 32'(4'b1110));
    checkOutput("first_seg", 32'(seg), 32'(7'h7F ^ 7'h71));
    checkOutput("first_pending", 32'(pending), 32'(1'b0));
    waitCycles(4);
    checkOutput("guard_an", 32'(an), 32'(4'b1111));
    waitCycles(1);
    checkOutput("digit1_an", 32'(an), 32'(4'b1101));
    checkOutput("digit1_seg", 32'(seg), 32'(7'h7F ^ 7'h77));
    waitCycles(15);
    checkOutput("frame_wrap_an", 32'(an), 32'(4'b1110));
    checkOutput("frame_wrap_seg", 32'(seg), 32'(7'h7F ^ 7'h71));

    // Mid-frame load on digit 1 waits for the next digit-0 entry
    waitCycles(6);
    applyStimulus(16'h0000, 4'h0, 1'b0);
    checkOutput("mid_pending", 32'(pending), 32'(1'b1));
    waitCycles(3);
    checkOutput("mid_d2_an", 32'(an), 32'(4'b1011));
    checkOutput("mid_d2_seg", 32'(seg), 32'(7'h7F ^ 7'h5B));
    waitCycles(5);
    checkOutput("mid_d3_an", 32'(an), 32'(4'b0111));
    checkOutput("mid_d3_seg", 32'(seg), 32'(7'h7F ^ 7'h06));
    checkOutput("mid_d3_pending", 32'(pending), 32'(1'b1));
    waitCycles(5);
    checkOutput("mid_d0_seg", 32'(seg), 32'(7'h7F ^ 7'h3F));
    checkOutput("mid_d0_pending", 32'(pending), 32'(1'b0));

    // Two loads inside one frame: last one wins
    applyStimulus(16'h1111, 4'h0, 1'b0);
    applyStimulus(16'h2222, 4'h0, 1'b0);
    checkOutput("twoload_pending", 32'(pending), 32'(1'b1));
    waitCycles(3);
    checkOutput("twoload_old_seg", 32'(seg), 32'(7'h7F ^ 7'h3F));
    waitCycles(15);
    checkOutput("twoload_d0_seg", 32'(seg), 32'(7'h7F ^ 7'h5B));
    checkOutput("twoload_d0_pending", 32'(pending), 32'(1'b0));
    waitCycles(5);
    checkOutput("twoload_d1_seg", 32'(seg), 32'(7'h7F ^ 7'h5B));

    // Reset during digit-2 SHOW discards the pending value
    applyStimulus(16'h3333, 4'h0, 1'b0);
    waitCycles(5);
    checkOutput("prereset_an", 32'(an), 32'(4'b1011));
    checkOutput("prereset_pending", 32'(pending), 32'(1'b1));
    resetn = 1'b0;
    waitCycles(1);
    checkBlank("midreset");
    checkOutput("midreset_digit_idx", 32'(digitIdx), 32'(2'd0));
    resetn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      waitCycles(1);
      checkBlank("postreset");
    end

    // Decode and blanking vectors, one digit per dwell
    for (int t = 0; t < NVEC; t++) begin
      resetn = 1'b0;
      waitCycles(2);
      resetn = 1'b1;
      waitCycles(1);
      applyStimulus(vecs[t].value, vecs[t].dpIn, vecs[t].blz);
      for (int d = 0; d < N; d++) begin
        if (d > 0) waitCycles(PS + GD);
        expAnV  = ~(4'b0001 << d);
        expSegV = 7'h7F ^ vecs[t].expSeg[d];
        expDpV  = ~vecs[t].expDp[d];
        checkOutput($sformatf("vec%0d_d%0d_an", t, d), 32'(an), 32'(expAnV));
        checkOutput($sformatf("vec%0d_d%0d_seg", t, d), 32'(seg), 32'(expSegV));
        checkOutput($sformatf("vec%0d_d%0d_dp", t, d), 32'(dp), 32'(expDpV));
        checkOutput($sformatf("vec%0d_d%0d_idx", t, d), 32'(digitIdx), 32'(d));
      end
    end

    waitCycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
